// File: rtl/bcd_pkg.sv
// Shared constants and state encoding for the digit-serial BCD adder.
package bcd_pkg;

  localparam int DIGIT_W = 4;
  localparam logic [3:0] BCD_MAX  = 4'd9;
  localparam logic [3:0] BCD_CORR = 4'd6;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    ADD  = 2'd1,
    DONE = 2'd2
  } state_t;

endpackage

// File: rtl/bcd_digit_add.sv
// Single-digit BCD adder with decimal correction and invalid-digit flag.
module bcd_digit_add
  import bcd_pkg::*;
(
  input  logic [3:0] a,
  input  logic [3:0] b,
  input  logic       ci,
  output logic [3:0] s,
  output logic       co,
  output logic       bad
);

  logic [4:0] t;

  // Binary sum is 5 bits wide so out-of-range digits still follow the same rule.
  assign t   = {1'b0, a} + {1'b0, b} + {4'd0, ci};
  assign co  = (t > {1'b0, BCD_MAX});
  assign s   = co ? (t[3:0] + BCD_CORR) : t[3:0];
  assign bad = (a > BCD_MAX) || (b > BCD_MAX);

endmodule

// File: rtl/bcd_serial_adder.sv
// Digit-serial multi-digit BCD adder: one decimal digit per clock, LSD first.
module bcd_serial_adder
  import bcd_pkg::*;
#(
  parameter int NDIG = 4
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    start,
  input  logic [DIGIT_W*NDIG-1:0] A,
  input  logic [DIGIT_W*NDIG-1:0] B,
  input  logic                    CI,
  output logic                    busy,
  output logic                    done,
  output logic [DIGIT_W*NDIG-1:0] S,
  output logic                    C,
  output logic                    err
);

  localparam int W  = DIGIT_W * NDIG;
  localparam int CW = $clog2(NDIG + 1);
  localparam logic [CW-1:0] LAST = CW'(NDIG - 1);

  state_t          state_q, state_d;
  logic            load, step, last;
  logic [W-1:0]    a_q, b_q, sum_q, sum_d;
  logic [CW-1:0]   idx_q;
  logic            carry_q;
  logic            errs_q, errs_d;
  logic [W-1:0]    s_q;
  logic            c_q, err_q;
  logic [3:0]      dig_s;
  logic            dig_co, dig_bad;

  bcd_digit_add u_digit (
    .a  (a_q[DIGIT_W-1:0]),
    .b  (b_q[DIGIT_W-1:0]),
    .ci (carry_q),
    .s  (dig_s),
    .co (dig_co),
    .bad(dig_bad)
  );

  // New digits enter at the top so digit 0 ends up at the bottom after NDIG shifts.
  generate
    if (NDIG == 1) begin : g_one
      assign sum_d = dig_s;
    end else begin : g_many
      assign sum_d = {dig_s, sum_q[W-1:DIGIT_W]};
    end
  endgenerate

  assign errs_d = errs_q | dig_bad;
  assign last   = (idx_q == LAST);

  always_comb begin
    state_d = state_q;
    load    = 1'b0;
    step    = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (start) begin
          load    = 1'b1;
          state_d = ADD;
        end
      end
      ADD: begin
        step = 1'b1;
        if (last) state_d = DONE;
      end
      DONE: begin
        if (start) begin
          load    = 1'b1;
          state_d = ADD;
        end else begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      a_q     <= '0;
      b_q     <= '0;
      sum_q   <= '0;
      idx_q   <= '0;
      carry_q <= 1'b0;
      errs_q  <= 1'b0;
      s_q     <= '0;
      c_q     <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      if (load) begin
        a_q     <= A;
        b_q     <= B;
        carry_q <= CI;
        idx_q   <= '0;
        errs_q  <= 1'b0;
      end else if (step) begin
        a_q     <= a_q >> DIGIT_W;
        b_q     <= b_q >> DIGIT_W;
        sum_q   <= sum_d;
        carry_q <= dig_co;
        errs_q  <= errs_d;
        idx_q   <= idx_q + CW'(1);
        if (last) begin
          s_q   <= sum_d;
          c_q   <= dig_co;
          err_q <= errs_d;
        end
      end
    end
  end

  assign busy = (state_q == ADD);
  assign done = (state_q == DONE);
  assign S    = s_q;
  assign C    = c_q;
  assign err  = err_q;

endmodule
